// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the FSM state encoding, default timing parameters and a counter-width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_MAX_RETRIES         = 3;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // A counter that counts 0..n-1 needs $clog2(n) bits, never fewer than one.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Resets to 0; the output is valid STAGES clock edges after the input settles.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up / recovery sequencer for the system PLL: holds the PLL in reset, waits for a
// debounced lock, releases the downstream reset, retries on timeout and latches a fault.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              restart_req,
    output logic              pll_rst,
    output logic              sys_rst_n,
    output logic              ready,
    output logic              fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt
);

    localparam int RST_W  = cnt_width(PLL_RST_CYCLES);
    localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_W  = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_MAX  = '1;

    pll_state_e         state_r;
    pll_state_e         next_state_s;
    logic [RST_W-1:0]   rst_cnt_r;
    logic [RST_W-1:0]   rst_cnt_nxt_s;
    logic [STAB_W-1:0]  stab_cnt_r;
    logic [STAB_W-1:0]  stab_cnt_nxt_s;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_nxt_s;
    logic [RETRY_W-1:0] retry_nxt_s;
    logic [RETRY_W-1:0] retry_inc_s;
    logic [LOSS_W-1:0]  loss_nxt_s;
    logic               lock_s;
    logic               timeout_s;
    logic               give_up_s;
    pll_state_e         tmo_state_s;
    logic [RETRY_W-1:0] tmo_retry_s;

    bit_sync #(
        .STAGES (2)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next-state, counter and retry/loss bookkeeping
    always_comb begin
        next_state_s   = state_r;
        rst_cnt_nxt_s  = '0;
        stab_cnt_nxt_s = '0;
        tmo_cnt_nxt_s  = '0;
        retry_nxt_s    = retry_cnt;
        loss_nxt_s     = lock_loss_cnt;

        timeout_s   = (tmo_cnt_r == TMO_LAST);
        retry_inc_s = retry_cnt + RETRY_W'(1);
        give_up_s   = (retry_inc_s == RETRY_MAX);
        tmo_state_s = give_up_s ? ST_FAULT : ST_PLL_RST;
        tmo_retry_s = give_up_s ? RETRY_MAX : retry_inc_s;

        if (restart_req) begin
            next_state_s = ST_PLL_RST;
            retry_nxt_s  = '0;
        end else begin
            case (state_r)
                ST_PLL_RST: begin
                    if (rst_cnt_r == RST_LAST) begin
                        next_state_s = ST_WAIT_LOCK;
                    end else begin
                        rst_cnt_nxt_s = rst_cnt_r + RST_W'(1);
                    end
                end
                // In WAIT_LOCK a timeout beats a fresh lock: RUN cannot be reached this cycle.
                ST_WAIT_LOCK: begin
                    if (timeout_s) begin
                        next_state_s = tmo_state_s;
                        retry_nxt_s  = tmo_retry_s;
                    end else if (lock_s) begin
                        next_state_s  = ST_STABLE;
                        tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    end else begin
                        tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (lock_s && (stab_cnt_r == STAB_LAST)) begin
                        next_state_s = ST_RUN;
                        retry_nxt_s  = '0;
                    end else if (timeout_s) begin
                        next_state_s = tmo_state_s;
                        retry_nxt_s  = tmo_retry_s;
                    end else if (!lock_s) begin
                        next_state_s  = ST_WAIT_LOCK;
                        tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                    end else begin
                        stab_cnt_nxt_s = stab_cnt_r + STAB_W'(1);
                        tmo_cnt_nxt_s  = tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        next_state_s = ST_PLL_RST;
                        loss_nxt_s   = (lock_loss_cnt == LOSS_MAX) ? lock_loss_cnt
                                                                   : lock_loss_cnt + LOSS_W'(1);
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    next_state_s = ST_FAULT;
                end
                default: begin
                    next_state_s = ST_PLL_RST;
                    retry_nxt_s  = '0;
                end
            endcase
        end
    end

    // State, counters and outputs registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_PLL_RST;
            rst_cnt_r     <= '0;
            stab_cnt_r    <= '0;
            tmo_cnt_r     <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            rst_cnt_r     <= rst_cnt_nxt_s;
            stab_cnt_r    <= stab_cnt_nxt_s;
            tmo_cnt_r     <= tmo_cnt_nxt_s;
            retry_cnt     <= retry_nxt_s;
            lock_loss_cnt <= loss_nxt_s;
            pll_rst       <= (next_state_s == ST_PLL_RST) || (next_state_s == ST_FAULT);
            sys_rst_n     <= (next_state_s == ST_RUN);
            ready         <= (next_state_s == ST_RUN);
            fault         <= (next_state_s == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a lock-run-length / window-age model checked
// every cycle, plus hand-computed literal checkpoints along a directed scenario.
module tb_pll_reset_sequencer;

    localparam int P_RST    = 4;
    localparam int P_STABLE = 8;
    localparam int P_TMO    = 40;
    localparam int P_MAX    = 3;

    localparam int M_PULSE = 0;
    localparam int M_SEEK  = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic check_en = 1'b0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TMO),
        .MAX_RETRIES         (P_MAX)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .restart_req   (restart_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode, age inside pulse / seek window, run length of consecutive lock,
    // retries and losses; s1/s2 delay pll_locked by the two synchronizer edges.
    typedef struct packed {
        int   mode;
        int   pulse_age;
        int   seek_age;
        int   run;
        int   retries;
        int   losses;
        logic s1;
        logic s2;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.mode = M_PULSE;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, logic locked, logic restart);
        model_t n;
        logic   lk;
        int     r;
        n    = c;
        lk   = c.s2;
        n.s1 = locked;
        n.s2 = c.s1;
        r    = lk ? c.run + 1 : 0;
        if (restart) begin
            n.mode = M_PULSE;
            n.pulse_age = 0;
            n.retries = 0;
        end else begin
            case (c.mode)
                M_PULSE: begin
                    if (c.pulse_age == P_RST - 1) begin
                        n.mode = M_SEEK;
                        n.seek_age = 0;
                        n.run = 0;
                    end else begin
                        n.pulse_age = c.pulse_age + 1;
                    end
                end
                M_SEEK: begin
                    // release needs one lock cycle to leave WAIT plus P_STABLE stable cycles
                    if (r == P_STABLE + 1) begin
                        n.mode = M_RUN;
                        n.retries = 0;
                    end else if (c.seek_age == P_TMO - 1) begin
                        if (c.retries + 1 == P_MAX) begin
                            n.mode = M_FAULT;
                            n.retries = P_MAX;
                        end else begin
                            n.mode = M_PULSE;
                            n.pulse_age = 0;
                            n.retries = c.retries + 1;
                        end
                    end else begin
                        n.seek_age = c.seek_age + 1;
                        n.run = r;
                    end
                end
                M_RUN: begin
                    if (!lk) begin
                        n.mode = M_PULSE;
                        n.pulse_age = 0;
                        n.losses = (c.losses < 255) ? c.losses + 1 : 255;
                    end
                end
                default: begin
                    n.mode = c.mode;
                end
            endcase
        end
        return n;
    endfunction

    // Advance the model on the same edges as the DUT
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= model_reset();
        end else begin
            m <= model_step(m, pll_locked, restart_req);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Compare all outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("model.pll_rst",  int'(pll_rst),   int'(m.mode == M_PULSE || m.mode == M_FAULT));
            chk("model.sys_rst_n", int'(sys_rst_n), int'(m.mode == M_RUN));
            chk("model.ready",    int'(ready),     int'(m.mode == M_RUN));
            chk("model.fault",    int'(fault),     int'(m.mode == M_FAULT));
            chk("model.retry_cnt", int'(retry_cnt), m.retries);
            chk("model.lock_loss_cnt", int'(lock_loss_cnt), m.losses);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        reset_n     = 1'b1;
        pll_locked  = 1'b0;
        restart_req = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.pll_rst", int'(pll_rst), 1);
        chk("reset.sys_rst_n", int'(sys_rst_n), 0);
        chk("reset.ready", int'(ready), 0);
        chk("reset.fault", int'(fault), 0);
        chk("reset.retry_cnt", int'(retry_cnt), 0);
        chk("reset.lock_loss_cnt", int'(lock_loss_cnt), 0);
        check_en = 1'b1;

        // Nominal bring-up, lock from cycle 10, release at 10+2+1+8
        release_reset();
        goto(3);  chk("nom.pll_rst_c3", int'(pll_rst), 1);
        goto(4);  chk("nom.pll_rst_c4", int'(pll_rst), 0);
        goto(10); pll_locked = 1'b1;
        goto(20); chk("nom.sys_rst_n_c20", int'(sys_rst_n), 0);
        goto(21); chk("nom.sys_rst_n_c21", int'(sys_rst_n), 1);
        chk("nom.ready_c21", int'(ready), 1);
        chk("nom.retry_c21", int'(retry_cnt), 0);

        // Lock loss in RUN, then normal re-sequence
        goto(30); pll_locked = 1'b0;
        goto(32); chk("loss.sys_rst_n_c32", int'(sys_rst_n), 1);
        goto(33); chk("loss.sys_rst_n_c33", int'(sys_rst_n), 0);
        chk("loss.pll_rst_c33", int'(pll_rst), 1);
        chk("loss.count_c33", int'(lock_loss_cnt), 1);
        goto(34); pll_locked = 1'b1;
        goto(45); chk("loss.ready_c45", int'(ready), 0);
        goto(46); chk("loss.ready_c46", int'(ready), 1);

        // restart_req in RUN
        goto(50); restart_req = 1'b1;
        goto(51); restart_req = 1'b0;
        chk("rst_run.pll_rst", int'(pll_rst), 1);
        chk("rst_run.sys_rst_n", int'(sys_rst_n), 0);
        chk("rst_run.loss", int'(lock_loss_cnt), 1);

        // One-cycle lock glitch mid-STABLE delays release from 64 to 70
        goto(58); pll_locked = 1'b0;
        goto(59); pll_locked = 1'b1;
        goto(64); chk("glitch.ready_c64", int'(ready), 0);
        chk("glitch.pll_rst_c64", int'(pll_rst), 0);
        goto(69); chk("glitch.ready_c69", int'(ready), 0);
        goto(70); chk("glitch.ready_c70", int'(ready), 1);

        // Permanent lock loss: three 40-cycle windows then FAULT
        goto(80);  pll_locked = 1'b0;
        goto(126); chk("tmo.pll_rst_c126", int'(pll_rst), 0);
        goto(127); chk("tmo.pll_rst_c127", int'(pll_rst), 1);
        chk("tmo.retry_c127", int'(retry_cnt), 1);
        goto(131); chk("tmo.pll_rst_c131", int'(pll_rst), 0);
        goto(171); chk("tmo.retry_c171", int'(retry_cnt), 2);
        goto(214); chk("tmo.fault_c214", int'(fault), 0);
        goto(215); chk("tmo.fault_c215", int'(fault), 1);
        chk("tmo.retry_c215", int'(retry_cnt), 3);
        chk("tmo.pll_rst_c215", int'(pll_rst), 1);
        goto(230); chk("tmo.fault_held", int'(fault), 1);
        chk("tmo.loss", int'(lock_loss_cnt), 2);

        // restart_req in FAULT, then bring-up again
        goto(235); restart_req = 1'b1;
        goto(236); restart_req = 1'b0;
        pll_locked = 1'b1;
        chk("rst_fault.pll_rst", int'(pll_rst), 1);
        chk("rst_fault.fault", int'(fault), 0);
        chk("rst_fault.retry", int'(retry_cnt), 0);
        chk("rst_fault.loss", int'(lock_loss_cnt), 2);
        goto(248); chk("rst_fault.ready_c248", int'(ready), 0);
        goto(249); chk("rst_fault.ready_c249", int'(ready), 1);

        // Stable completion on the last timeout cycle wins over the timeout
        goto(255); pll_locked = 1'b0;
        goto(291); pll_locked = 1'b1;
        goto(301); chk("edge.ready_c301", int'(ready), 0);
        goto(302); chk("edge.ready_c302", int'(ready), 1);
        chk("edge.pll_rst_c302", int'(pll_rst), 0);
        chk("edge.loss_c302", int'(lock_loss_cnt), 3);

        // Asynchronous reset between clock edges while in STABLE
        goto(310); pll_locked = 1'b0;
        goto(313); pll_locked = 1'b1;
        goto(320);
        #2 reset_n = 1'b0;
        #1;
        chk("async.pll_rst", int'(pll_rst), 1);
        chk("async.sys_rst_n", int'(sys_rst_n), 0);
        chk("async.ready", int'(ready), 0);
        chk("async.fault", int'(fault), 0);
        chk("async.retry", int'(retry_cnt), 0);
        chk("async.loss", int'(lock_loss_cnt), 0);
        release_reset();
        goto(3);  chk("post.pll_rst_c3", int'(pll_rst), 1);
        goto(4);  chk("post.pll_rst_c4", int'(pll_rst), 0);
        goto(12); chk("post.ready_c12", int'(ready), 0);
        goto(13); chk("post.ready_c13", int'(ready), 1);
        goto(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
